// File: rtl/fpu_pkg.sv
// Shared definitions for the single-precision FPU datapath stages.
// Field widths, status bit layout and special-result encodings used by the output stages.
package fpu_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;
    localparam int WORD_W = EXP_W + MAN_W + 1;

    // Positions inside the grs triple handed over by the normaliser
    localparam int GRS_G = 2;
    localparam int GRS_R = 1;
    localparam int GRS_S = 0;

    localparam int ST_INV  = 4;
    localparam int ST_OVF  = 3;
    localparam int ST_UNF  = 2;
    localparam int ST_ZERO = 1;
    localparam int ST_NX   = 0;

    localparam logic [WORD_W-1:0] QNAN     = 32'h7FC0_0000;
    localparam logic [WORD_W-1:0] POS_INF  = 32'h7F80_0000;
    localparam logic [WORD_W-1:0] POS_ZERO = 32'h0000_0000;

    typedef struct packed {
        logic inv;
        logic ovf;
        logic unf;
        logic zero;
        logic nx;
    } fp_status_t;

    typedef enum logic [2:0] {
        RES_NORMAL,
        RES_NAN,
        RES_INF,
        RES_ZERO,
        RES_UFLOW
    } res_class_t;

endpackage

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even of a normalised mantissa with hidden bit.
// Shared by the multiplier and adder output stages.
module fp_round_rne
    import fpu_pkg::*;
#(
    parameter int EXP_W = fpu_pkg::EXP_W,
    parameter int MAN_W = fpu_pkg::MAN_W
) (
    input  logic [MAN_W:0]   mant_in,
    input  logic [2:0]       grs,
    input  logic [EXP_W-1:0] exp_in,
    output logic [MAN_W:0]   mant_out,
    output logic [EXP_W:0]   exp_out,
    output logic             carry,
    output logic             inexact
);

    logic             round_up;
    logic [MAN_W+1:0] sum;

    // A mantissa carry-out renormalises to 1.000... and bumps the exponent;
    // exp_out keeps the extra bit so callers can see a wrap past all-ones.
    always_comb begin
        round_up = grs[GRS_G] & (grs[GRS_R] | grs[GRS_S] | mant_in[0]);
        sum      = {1'b0, mant_in} + {{(MAN_W+1){1'b0}}, round_up};
        carry    = sum[MAN_W+1];
        mant_out = carry ? sum[MAN_W+1:1] : sum[MAN_W:0];
        exp_out  = {1'b0, exp_in} + {{EXP_W{1'b0}}, carry};
        inexact  = |grs;
    end

endmodule

// File: rtl/fp_mul_round_pack.sv
// Multiplier output stage: rounds, selects special results and packs the IEEE word
// through a two-stage valid/ready pipeline. FPU_STATUS_STICKY_EN enables the sticky status register.
module fp_mul_round_pack #(
    parameter int EXP_W = fpu_pkg::EXP_W,
    parameter int MAN_W = fpu_pkg::MAN_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   sign_z,
    input  logic [EXP_W-1:0]       Ez,
    input  logic [MAN_W:0]         Mz,
    input  logic [2:0]             grs,
    input  logic                   invalid_flag,
    input  logic                   overflow_flag,
    input  logic                   zero_flag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    input  logic                   status_clr,
    output logic [4:0]             status
);

    import fpu_pkg::*;

    localparam logic [EXP_W:0] EXP_SAT = {1'b0, {EXP_W{1'b1}}};

    logic               s1_valid;
    logic               s1_sign;
    logic [EXP_W-1:0]   s1_exp;
    logic [MAN_W:0]     s1_mant;
    logic [2:0]         s1_grs;
    logic               s1_inv;
    logic               s1_ovf;
    logic               s1_zero;

    logic [MAN_W:0]     mant_rnd;
    logic [EXP_W:0]     exp_rnd;
    logic               rnd_carry_unused;
    logic               rnd_hidden_unused;
    logic               rnd_nx;

    res_class_t         res_class;
    logic [EXP_W+MAN_W:0] res_next;
    fp_status_t         flags_next;
    fp_status_t         s2_flags;

    logic               s2_adv;
    logic               out_fire;

    assign s2_adv   = ~out_valid | out_ready;
    assign in_ready = ~s1_valid | s2_adv;
    assign out_fire = out_valid & out_ready;

    // Stage 1 captures the raw normalised product whenever it has room
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_exp   <= '0;
            s1_mant  <= '0;
            s1_grs   <= '0;
            s1_inv   <= 1'b0;
            s1_ovf   <= 1'b0;
            s1_zero  <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign <= sign_z;
                s1_exp  <= Ez;
                s1_mant <= Mz;
                s1_grs  <= grs;
                s1_inv  <= invalid_flag;
                s1_ovf  <= overflow_flag;
                s1_zero <= zero_flag;
            end
        end
    end

    fp_round_rne #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .mant_in  (s1_mant),
        .grs      (s1_grs),
        .exp_in   (s1_exp),
        .mant_out (mant_rnd),
        .exp_out  (exp_rnd),
        .carry    (rnd_carry_unused),
        .inexact  (rnd_nx)
    );

    assign rnd_hidden_unused = mant_rnd[MAN_W];

    // Underflow looks at the pre-rounding exponent: subnormals are never produced
    always_comb begin
        res_class = RES_NORMAL;
        if (s1_inv)
            res_class = RES_NAN;
        else if (s1_ovf || (exp_rnd >= EXP_SAT))
            res_class = RES_INF;
        else if (s1_zero)
            res_class = RES_ZERO;
        else if (s1_exp == '0)
            res_class = RES_UFLOW;
    end

    always_comb begin
        res_next   = {s1_sign, exp_rnd[EXP_W-1:0], mant_rnd[MAN_W-1:0]};
        flags_next = '0;
        case (res_class)
            RES_NAN: begin
                res_next       = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
                flags_next.inv = 1'b1;
            end
            RES_INF: begin
                res_next       = {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                flags_next.ovf = 1'b1;
                flags_next.nx  = rnd_nx;
            end
            RES_ZERO: begin
                res_next        = {s1_sign, {(EXP_W+MAN_W){1'b0}}};
                flags_next.zero = 1'b1;
            end
            RES_UFLOW: begin
                res_next       = {s1_sign, {(EXP_W+MAN_W){1'b0}}};
                flags_next.unf = 1'b1;
                flags_next.nx  = 1'b1;
            end
            default: begin
                flags_next.nx = rnd_nx;
            end
        endcase
    end

    // Stage 2 holds the packed word until downstream takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            s2_flags  <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                result   <= res_next;
                s2_flags <= flags_next;
            end
        end
    end

`ifdef FPU_STATUS_STICKY_EN
    fp_status_t status_q;

    // A clear drops history but keeps whatever is being delivered this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            status_q <= '0;
        else if (status_clr)
            status_q <= out_fire ? s2_flags : '0;
        else if (out_fire)
            status_q <= status_q | s2_flags;
    end

    assign status = status_q;
`else
    logic status_clr_unused;
    logic out_fire_unused;

    assign status_clr_unused = status_clr;
    assign out_fire_unused   = out_fire;
    assign status            = out_valid ? s2_flags : 5'b0;
`endif

endmodule

// File: doc/fp_mul_round_pack.md
Name: fp_mul_round_pack

Overview:
- Output stage of the single-precision multiplier.
- Consumes the normalised product (sign, biased exponent, 24-bit mantissa with hidden bit, guard/round/sticky bits) and the invalid/overflow/zero flags from the exception-detection stage.
- Performs round-to-nearest-even, selects the special results, and packs the IEEE-754 word.
- Two-stage valid/ready pipeline; accumulates a sticky status register readable by the FPU control logic.

Parameters:
- EXP_W, 8, exponent width.
- MAN_W, 23, stored fraction width (datapath mantissa is MAN_W+1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream word valid
- in_ready  out  1  stage can accept
- sign_z  in  1  product sign
- Ez  in  EXP_W  biased, normalised exponent
- Mz  in  MAN_W+1  normalised mantissa, bit MAN_W = hidden 1
- grs  in  3  guard, round, sticky
- invalid_flag  in  1  from exception stage
- overflow_flag  in  1  from exception stage
- zero_flag  in  1  from exception stage
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- result  out  EXP_W+MAN_W+1  packed float
- status_clr  in  1  clear sticky status
- status  out  5  {invalid, overflow, underflow, zero, inexact}

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all stage registers 0; out_valid=0; result=0; status=0. in_ready=1 after reset. Reset mid-operation discards in-flight words without emitting them.
- Pipeline:
  - S1 registers inputs on in_valid & in_ready.
  - S2 registers the rounded/packed result.
  - Latency is 2 cycles from input handshake to out_valid when out_ready is held high; throughput 1 word/cycle.
- Handshake:
  - s2_adv = ~out_valid | out_ready.
  - in_ready = ~s1_valid | s2_adv.
  - Combinational ready chain; no bubbles.
  - result and out_valid are held stable while out_valid & ~out_ready.
- Rounding (S1→S2):
  - G=grs[2], R=grs[1], S=grs[0].
  - round_up = G & (R | S | Mz[0]).
  - Sum is MAN_W+2 bits. On carry-out, the mantissa becomes 1.000…, exponent+1.
  - inexact = |grs.
- Selection priority:
  - invalid → 32'h7FC00000 (sign 0).
  - else overflow_flag, or rounded exponent == 255 → {sign_z, 8'hFF, 23'h0}, set overflow.
  - else zero_flag → {sign_z, 31'h0}.
  - else Ez==0 (underflow; no subnormals produced) → {sign_z, 31'h0}, set underflow and inexact.
  - else normal → {sign_z, Ez', Mz'[22:0]}.
- Flags: the inexact flag is suppressed for invalid and zero results.
- Status: OR-ed in on output handshake (out_valid & out_ready). If status_clr and a set occur in the same cycle, the new event bits survive and the old bits clear.

Optional Feature:
- Macro: FPU_STATUS_STICKY_EN.
- Defined: status behaves as the sticky register described above.
- Undefined: no status register; status = flags of the word currently in S2, gated by out_valid. status_clr is ignored.

Decomposition:
- Shared package fpu_pkg:
  - EXP_W, MAN_W, BIAS=127.
  - QNAN constant 32'h7FC00000.
  - Status bit indices (ST_INV=4 … ST_NX=0).
  - Special-result encodings.
- One natural sub-module: fp_round_rne, purely combinational (Mz, grs, Ez → Mz', Ez', carry, inexact). It is reused by the adder output stage.

Test Plan:
- Ez=128, Mz=24'h900000, grs=0, flags 0 → result 32'h40100000 two cycles later, status=0.
- Ez=127, Mz=24'h800001, grs=3'b100 → tie, odd LSB rounds up → 32'h3F800002, inexact set. Same with Mz=24'h800000 → 32'h3F800000.
- Ez=127, Mz=24'hFFFFFF, grs=3'b110 → carry → 32'h40000000. Ez=254, sign_z=1, same Mz/grs → 32'hFF800000, overflow+inexact set.
- invalid_flag=1 together with overflow_flag=1 → 32'h7FC00000, status[4] only. Then status_clr pulse → status=0. Clear coincident with a zero_flag word → status=5'b00010.
- Back-to-back 4 words, out_ready low for cycles 3–5:
  - in_ready drops after S1 and S2 fill.
  - result is held stable while stalled.
  - All 4 words are delivered in order, none lost or duplicated.
- rst_n asserted asynchronously with 2 words in flight → out_valid=0 and status=0 immediately. No stale word is emitted after release.
